// File: rtl/block_ram_nrw.sv
`default_nettype none
// ============================================================================
// Module   : block_ram_nrw
// Purpose  : Multi-port block RAM with NUM_PORTS independent read/write ports.
//            Every port uses a valid/bp request-response handshake and has its
//            own registered response (1-cycle read latency, read-old-data).
//            Same-cycle writes to one address resolve to the lowest-index port.
//            Out-of-range addresses (addr >= DEPTH) drop writes and return 0.
// Optional : define BLOCK_RAM_CLEAR_EN to add a post-reset sweep that zeroes
//            the whole memory (one word per cycle) while holding every
//            request backpressure bit high.
// Ports    : clk                - clock
//            resetn             - synchronous, active-low reset
//            i_port_req         - flattened requests, port p at [p*RW +: RW],
//                                 RW = WIDTH+ADDR_WIDTH+1; bit 0 = wr,
//                                 [WIDTH:1] = data, [WIDTH+ADDR_WIDTH:WIDTH+1]
//                                 = addr
//            i_port_req_valid   - per-port request valid
//            o_port_req_bp      - per-port request backpressure
//            o_port_resp        - per-port response data, port p at
//                                 [p*WIDTH +: WIDTH]
//            o_port_resp_valid  - per-port response valid
//            i_port_resp_bp     - per-port response backpressure
// Revision : 1.0 - initial release
// ============================================================================
module block_ram_nrw #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_PORTS  = 2
) (
  input  logic                                      clk,
  input  logic                                      resetn,
  input  logic [NUM_PORTS*(WIDTH+ADDR_WIDTH+1)-1:0] i_port_req,
  input  logic [NUM_PORTS-1:0]                      i_port_req_valid,
  output logic [NUM_PORTS-1:0]                      o_port_req_bp,
  output logic [NUM_PORTS*WIDTH-1:0]                o_port_resp,
  output logic [NUM_PORTS-1:0]                      o_port_resp_valid,
  input  logic [NUM_PORTS-1:0]                      i_port_resp_bp
);

  // Width of one request slice.
  localparam int c_req_w = WIDTH + ADDR_WIDTH + 1;
  // Width of the physical word index into the storage array.
  localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH widened by one bit so addr < DEPTH is an unsigned compare with no
  // truncation, even when DEPTH == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(DEPTH);

  // --------------------------------------------------------------------------
  // Storage and per-port state
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]      r_mem        [DEPTH];
  logic [WIDTH-1:0]      r_resp       [NUM_PORTS];
  logic [NUM_PORTS-1:0]  r_resp_valid;

  // Decoded request fields
  logic                  w_wr         [NUM_PORTS];
  logic [WIDTH-1:0]      w_wdata      [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] w_addr       [NUM_PORTS];
  logic [c_idx_w-1:0]    w_idx        [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_in_range;
  logic [NUM_PORTS-1:0]  w_req_bp;
  logic [NUM_PORTS-1:0]  w_accept;
  logic [NUM_PORTS-1:0]  w_wen;

  // High while the optional clear sweep owns the memory.
  logic                  w_clearing;

  // --------------------------------------------------------------------------
  // Optional clear sweep
  // --------------------------------------------------------------------------
`ifdef BLOCK_RAM_CLEAR_EN
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_t;

  localparam logic [c_idx_w-1:0] c_last_addr = c_idx_w'(DEPTH - 1);

  clr_state_t          r_clr_state;
  logic [c_idx_w-1:0]  r_clr_addr;
  logic                r_clr_busy;

  // r_clr_busy is a registered copy of "state == ST_CLEAR" so the
  // backpressure path sees a flop output rather than a state decode.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_clr_state <= ST_CLEAR;
      r_clr_addr  <= '0;
      r_clr_busy  <= 1'b1;
    end else begin
      case (r_clr_state)
        ST_CLEAR: begin
          if (r_clr_addr == c_last_addr) begin
            r_clr_state <= ST_RUN;
            r_clr_busy  <= 1'b0;
          end else begin
            r_clr_addr  <= r_clr_addr + c_idx_w'(1);
          end
        end
        ST_RUN: begin
          r_clr_busy <= 1'b0;
        end
        default: begin
          r_clr_state <= ST_CLEAR;
          r_clr_addr  <= '0;
          r_clr_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign w_clearing = r_clr_busy;
`else
  assign w_clearing = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Request decode, backpressure and acceptance
  // --------------------------------------------------------------------------
  always_comb begin
    w_wr       = '{default: '0};
    w_wdata    = '{default: '0};
    w_addr     = '{default: '0};
    w_idx      = '{default: '0};
    w_in_range = '0;
    w_req_bp   = '0;
    w_accept   = '0;
    w_wen      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_wr[p]       = i_port_req[p*c_req_w];
      w_wdata[p]    = i_port_req[p*c_req_w + 1 +: WIDTH];
      w_addr[p]     = i_port_req[p*c_req_w + WIDTH + 1 +: ADDR_WIDTH];
      w_idx[p]      = w_addr[p][c_idx_w-1:0];
      w_in_range[p] = ({1'b0, w_addr[p]} < c_depth);
      // A held response blocks only its own port; streaming with the
      // response being consumed every cycle sees no bubble.
      w_req_bp[p]   = (r_resp_valid[p] & i_port_resp_bp[p]) | w_clearing;
      w_accept[p]   = i_port_req_valid[p] & ~w_req_bp[p];
      w_wen[p]      = w_accept[p] & w_wr[p] & w_in_range[p];
    end
  end

  // --------------------------------------------------------------------------
  // Memory write path
  // --------------------------------------------------------------------------
  // Ports are visited from highest to lowest index; with non-blocking
  // assignments the last write to an element wins, so the lowest-index
  // port takes priority on an address collision. Nothing is written while
  // reset is asserted.
  always_ff @(posedge clk) begin
    if (resetn) begin
`ifdef BLOCK_RAM_CLEAR_EN
      if (w_clearing) begin
        r_mem[r_clr_addr] <= '0;
      end
`endif
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (w_wen[p]) begin
          r_mem[w_idx[p]] <= w_wdata[p];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-port response registers
  // --------------------------------------------------------------------------
  // The read samples r_mem before this edge's writes land, which gives
  // read-old-data for reads and writes alike (a write returns the value it
  // overwrote).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_resp_valid <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_resp[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_accept[p]) begin
          r_resp_valid[p] <= 1'b1;
          r_resp[p]       <= w_in_range[p] ? r_mem[w_idx[p]] : '0;
        end else if (!(r_resp_valid[p] && i_port_resp_bp[p])) begin
          // Response consumed (or none pending) and nothing new accepted.
          r_resp_valid[p] <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    o_port_resp = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      o_port_resp[p*WIDTH +: WIDTH] = r_resp[p];
    end
  end

  assign o_port_req_bp     = w_req_bp;
  assign o_port_resp_valid = r_resp_valid;

endmodule
`default_nettype wire

// File: doc/block_ram_nrw.md
Name: block_ram_nrw

Overview:
- Parametrised multi-port block RAM with NumPorts independent read/write ports. Every port uses the codebase valid/bp request-response handshake.
- Unlike the combinational-read 2-port RAM, reads are registered (1-cycle latency, BRAM-inferable). Each port has its own response holding register, so backpressure stalls only that port.
- Same-cycle write conflicts are resolved deterministically.
- Instantiated by the memory backend for any RAM with 1..8 ports.

Parameters:
- Width, 8: data width in bits.
- Depth, 8: number of words; need not be a power of 2.
- AddrWidth, 8: address field width; must be at least clog2(Depth).
- NumPorts, 2: number of RW ports, 1..8.

Ports:
- clk  input  1  clock.
- resetn  input  1  reset, synchronous, active-low.
- port_req  input  NumPorts*(Width+AddrWidth+1)  flattened requests. Port p occupies slice [p*RW +: RW], where RW = Width+AddrWidth+1. Within a slice: bit 0 = wr, [Width:1] = data, [Width+AddrWidth:Width+1] = addr.
- port_req_valid  input  NumPorts  per-port request valid.
- port_req_bp  output  NumPorts  per-port request backpressure.
- port_resp  output  NumPorts*Width  per-port response data; port p at [p*Width +: Width].
- port_resp_valid  output  NumPorts  per-port response valid.
- port_resp_bp  input  NumPorts  per-port response backpressure.

Behaviour:
- Acceptance: port p accepts a request in a cycle where port_req_valid[p] && ~port_req_bp[p].
- Backpressure: port_req_bp[p] = port_resp_valid[p] && port_resp_bp[p] (combinational; no bubble on streaming).
  - CLEAR_EN builds additionally force it high while the clear sweep runs (see Optional Feature).
- Response, 1 cycle after acceptance:
  - port_resp_valid[p] rises.
  - port_resp[p] = memory contents at addr *before* that cycle's writes (read-old-data semantics). This holds for reads and writes alike; a write returns the overwritten value.
- Response hold: while port_resp_valid[p] && port_resp_bp[p], port_resp[p] and port_resp_valid[p] stay frozen and the port accepts nothing.
- Response drain: if the response is consumed (~bp) and no new request is accepted that cycle, port_resp_valid[p] falls next cycle.
- Reset values: port_resp_valid = 0 and port_resp = 0 for all ports. Memory contents are not reset unless CLEAR_EN is defined.
- Reset mid-operation: any pending response is discarded; valid drops on the next edge. Writes presented in a reset cycle are not performed.
- Write conflict: if several ports accept writes to the same address in one cycle, the lowest-index port wins. Higher-index writes to that address are dropped silently but still receive their response.
- Read/write in the same cycle, different ports, same address: the reader gets the old data. The write is visible to any access accepted on a later cycle.
- Out-of-range addr (addr >= Depth): writes are ignored and the response data is 0. This is not an error.
- Ports are fully independent: no cross-port stalls other than the conflict priority rule.

Optional Feature:
- Macro: BLOCK_RAM_CLEAR_EN.
- Defined: a two-state FSM, CLEAR then RUN, is added.
  - On reset the FSM enters CLEAR, the clear counter resets to 0, and memory writes are suppressed for that cycle.
  - In CLEAR, one word per cycle is written to zero, addresses 0..Depth-1.
  - Every port_req_bp bit is forced to 1 and no requests are accepted.
  - After address Depth-1 is written, the FSM moves to RUN. port_req_bp is first released in the cycle after the last clear write, i.e. Depth cycles after reset deasserts.
  - Reset during CLEAR restarts the sweep from 0.
- Undefined: no FSM and no counter. Requests are accepted in the first cycle after reset deasserts; memory powers up undefined.

Test Plan:
- Width=8, Depth=8, NumPorts=2. Port0 writes 0xA5 to addr 3, then reads addr 3 on the next cycle -> write response data = prior contents; read response = 0xA5 one cycle after acceptance.
- Port0 and port1 write addr 5 in the same cycle (0x11 and 0x22), then port1 reads addr 5 -> read returns 0x11; both write responses are valid one cycle later.
- Port1 reads addr 2 (holding 0x33) while port0 writes 0x44 to addr 2 in the same cycle -> port1 response = 0x33; a subsequent read returns 0x44.
- Port0 streams reads of addr 0..3 with port_resp_bp[0] high for 3 cycles after the first response -> port_resp[0] holds its value, port_req_bp[0] = 1, no request lost; order preserved 0,1,2,3. Port1 keeps its full throughput meanwhile.
- Port0 writes 0x7F to addr 9 (>= Depth), then reads addr 9 -> write dropped; read response = 0x00; addresses 0..7 unchanged.
- With BLOCK_RAM_CLEAR_EN, Depth=8, assert and then release resetn -> port_req_bp = 2'b11 for exactly 8 cycles, then 0; reads of every address return 0x00. Reset asserted at sweep address 4 -> sweep restarts and bp stays high for 8 more cycles.
